// File: rtl/rgb2ycbcr_422_if.sv
// Pixel-stream bundle between the timing source and the colour converter.
// master drives RGB + timing in; slave (the converter) drives YCbCr + timing out.
interface rgb2ycbcr_422_if;
  logic       in_de, in_hs, in_vs;
  logic [7:0] in_r, in_g, in_b;
  logic       out_de, out_hs, out_vs;
  logic [7:0] out_y, out_cb, out_cr, out_c;
  logic       out_cphase;

  modport master (
    output in_de, in_hs, in_vs, in_r, in_g, in_b,
    input  out_de, out_hs, out_vs, out_y, out_cb, out_cr, out_c, out_cphase
  );
  modport slave (
    input  in_de, in_hs, in_vs, in_r, in_g, in_b,
    output out_de, out_hs, out_vs, out_y, out_cb, out_cr, out_c, out_cphase
  );
endinterface

// File: rtl/rgb2ycbcr_422.sv
// RGB888 -> BT.601 studio-range YCbCr with optional 4:2:2 chroma averaging.
// Fixed 5-clock pipeline; DE/HS/VS delayed by the same amount.
module rgb2ycbcr_422 #(
  parameter bit MODE_422 = 1'b1,
  parameter int LATENCY  = 5
) (
  input  logic           hdmi_clk,
  input  logic           rst_n,
  rgb2ycbcr_422_if.slave vif
);
  localparam int STAGES = 5;

  typedef logic signed [17:0] prod_t;
  typedef logic signed [19:0] sum_t;
  typedef struct packed { logic [7:0] y, cb, cr; } ycc_t;
  localparam ycc_t YCC_IDLE = '{y: 8'd16, cb: 8'd128, cr: 8'd128};

  if (LATENCY != STAGES) begin : g_lat_chk
    $error("rgb2ycbcr_422: LATENCY must be 5");
  end

  function automatic logic [7:0] sat(input sum_t s, input sum_t ofs, input sum_t hi);
    sum_t v;
    v = (s >>> 8) + ofs;
    if (v < 20'sd16) return 8'd16;
    if (v > hi)      return hi[7:0];
    return v[7:0];
  endfunction

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  logic [STAGES:1] de_pipe_q, hs_pipe_q, vs_pipe_q;
  prod_t prod_d [9];
  prod_t prod_q [9];
  sum_t  sum_d  [3];
  sum_t  sum_q  [3];
  ycc_t  s3_d, s3_q, s4_q, s5_q;
  logic [7:0] c_d, c_q;
  logic       cph_d, cph_q, odd_d, odd_q;

  // S1 products, S2 rounded sums, S3 shift/offset/clamp
  always_comb begin
    prod_t r, g, b;
    r = $signed({10'd0, vif.in_r});
    g = $signed({10'd0, vif.in_g});
    b = $signed({10'd0, vif.in_b});
    prod_d[0] =  18'sd66  * r;
    prod_d[1] =  18'sd129 * g;
    prod_d[2] =  18'sd25  * b;
    prod_d[3] = -18'sd38  * r;
    prod_d[4] = -18'sd74  * g;
    prod_d[5] =  18'sd112 * b;
    prod_d[6] =  18'sd112 * r;
    prod_d[7] = -18'sd94  * g;
    prod_d[8] = -18'sd18  * b;
    for (int i = 0; i < 3; i++)
      sum_d[i] = sum_t'(prod_q[3*i]) + sum_t'(prod_q[3*i+1]) + sum_t'(prod_q[3*i+2]) + 20'sd128;
    s3_d.y  = sat(sum_q[0], 20'sd16,  20'sd235);
    s3_d.cb = sat(sum_q[1], 20'sd128, 20'sd240);
    s3_d.cr = sat(sum_q[2], 20'sd128, 20'sd240);
  end

  // Chroma mux for the pixel in S4: S3 is its lookahead partner, S5 holds the even
  // pixel of the pair when S4 is odd. A DE-low predecessor always restarts at even.
  always_comb begin
    odd_d = 1'b0;
    cph_d = 1'b0;
    c_d   = 8'd128;
    if (de_pipe_q[4]) begin
      if (!MODE_422) begin
        c_d = s4_q.cb;
      end else if (de_pipe_q[5] && !odd_q) begin
        odd_d = 1'b1;
        cph_d = 1'b1;
        c_d   = avg(s5_q.cr, s4_q.cr);
      end else if (de_pipe_q[3]) begin
        c_d = avg(s4_q.cb, s3_q.cb);
      end else begin
        c_d = s4_q.cb;
      end
    end
  end

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe_q <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int i = 0; i < 3; i++) sum_q[i]  <= '0;
      s3_q  <= YCC_IDLE;
      s4_q  <= YCC_IDLE;
      s5_q  <= YCC_IDLE;
      c_q   <= 8'd128;
      cph_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      de_pipe_q <= {de_pipe_q[STAGES-1:1], vif.in_de};
      hs_pipe_q <= {hs_pipe_q[STAGES-1:1], vif.in_hs};
      vs_pipe_q <= {vs_pipe_q[STAGES-1:1], vif.in_vs};
      prod_q <= prod_d;
      sum_q  <= sum_d;
      s3_q   <= s3_d;
      s4_q   <= s3_q;
      s5_q   <= s4_q;
      c_q    <= c_d;
      cph_q  <= cph_d;
      odd_q  <= odd_d;
    end
  end

  assign vif.out_de     = de_pipe_q[STAGES];
  assign vif.out_hs     = hs_pipe_q[STAGES];
  assign vif.out_vs     = vs_pipe_q[STAGES];
  assign vif.out_y      = s5_q.y;
  assign vif.out_cb     = s5_q.cb;
  assign vif.out_cr     = s5_q.cr;
  assign vif.out_c      = c_q;
  assign vif.out_cphase = cph_q;
endmodule
